mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port opcode  input  6  instruction[31:26], held stable by the instruction register after FETCH.
REQ-005 SHALL have port funct  input  6  instruction[5:0].
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have port alu_ct  output  4  ALU operation code: 0 AND, 1 OR, 2 ADD, 6 SUB.
REQ-008 SHALL have ports alu_src_a (1), alu_src_b (2; 00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2), pc_source (2; 00 ALU, 01 ALUOut, 10 jump target), all outputs.
REQ-009 SHALL have 1-bit outputs pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal_op.
REQ-010 SHALL have outputs state (4 bits, current state) and instr_count (CNT_W bits).

Function
REQ-011 SHALL be a Moore FSM: every output except pc_en in BRANCH is a decode of the state register only.
REQ-012 SHALL use the states and encodings RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10; unused encodings go to RST on the next cycle.
REQ-013 SHALL drive, in FETCH: mem_read=1, ir_write=1, alu_src_a=0, alu_src_b=01, alu_ct=2, pc_source=00, pc_en=1.
REQ-014 SHALL drive, in DECODE: alu_src_a=0, alu_src_b=11, alu_ct=2; next state is MEMADR for 100011/101011, EXEC for 000000, BRANCH for 000100, JUMP for 000010; otherwise FETCH.
REQ-015 SHALL drive, in MEMADR: alu_src_a=1, alu_src_b=10, alu_ct=2; next state MEMRD for lw, MEMWR for sw.
REQ-016 SHALL drive mem_read=1 and iord=1 in MEMRD (then MEMWB); reg_write=1 and mem_to_reg=1 in MEMWB; mem_write=1 and iord=1 in MEMWR.
REQ-017 SHALL drive, in EXEC: alu_src_a=1, alu_src_b=00, and alu_ct from funct (100100→0, 100101→1, 100000→2, 100010→6); next state ALUWB.
REQ-018 SHALL drive reg_write=1 and reg_dst=1 in ALUWB.
REQ-019 SHALL drive, in BRANCH: alu_src_a=1, alu_src_b=00, alu_ct=6, pc_source=01, pc_en=zero (zero sampled in that cycle only).
REQ-020 SHALL drive pc_source=10 and pc_en=1 in JUMP.
REQ-021 SHALL return to FETCH after MEMWB, MEMWR, ALUWB, BRANCH and JUMP, and SHALL drive every output not listed for a state to 0.
REQ-022 SHALL take 5 cycles for lw, 4 for sw and R-type, and 3 for beq and j, counted from FETCH to the next FETCH.
REQ-023 SHALL assert illegal_op for exactly the one DECODE cycle when the opcode is unsupported, or when opcode=000000 and funct is unsupported; the next state is then FETCH, with no writeback.
REQ-024 SHALL increment instr_count on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH or JUMP, wrapping modulo 2^CNT_W; illegal instructions SHALL NOT be counted.

Reset
REQ-025 SHALL force state=RST and instr_count=0 asynchronously whenever rst_n=0, including mid-instruction.
REQ-026 SHALL drive all outputs to 0 in RST, including alu_ct=0 and pc_en=0.
REQ-027 SHALL go from RST to FETCH on the first rising clk edge after rst_n deasserts.

Configuration
REQ-028 SHALL use the macro MC_CONTROL_JUMP_EN: when defined, opcode 000010 goes to JUMP; when undefined, the JUMP state is absent and 000010 is treated as illegal (REQ-023).

Structure
REQ-029 SHALL take the state encodings, opcode and funct constants, alu_ct codes (AND, OR, ADD, SUB) and alu_src_b/pc_source codes from the shared package mc_pkg.
REQ-030 SHALL implement the funct→alu_ct mapping, with a valid flag, as the sub-module alu_decoder.

Verification
REQ-031 SHALL cover: lw (opcode 100011) after reset → state sequence 1,2,3,4,5,1; mem_read=1 in states 1 and 4; reg_write=1 only in 5; instr_count=1.
REQ-032 SHALL cover: R-type with funct 100010 → alu_ct=6 in EXEC, reg_write=1 and reg_dst=1 in ALUWB, 4 cycles total.
REQ-033 SHALL cover: beq with zero=1, then beq with zero=0 → pc_en=1 in the first BRANCH cycle and 0 in the second; both take 3 cycles.
REQ-034 SHALL cover: opcode 111111, and R-type with funct 101010 → illegal_op pulses 1 cycle each, the next state is FETCH, and instr_count is unchanged.
REQ-035 SHALL cover: rst_n pulsed low during MEMRD → state=0 and all outputs 0 immediately; FETCH on the first edge after release.
REQ-036 SHALL cover: opcode 000010 with MC_CONTROL_JUMP_EN defined → JUMP with pc_source=10; with the macro undefined → illegal_op=1.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes, funct codes, ALU and mux selects.
// MC_CONTROL_JUMP_EN adds the JUMP state encoding.
package mc_pkg;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
`ifdef MC_CONTROL_JUMP_EN
        , S_JUMP = 4'd10
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_SEXT = 2'b10;
    localparam logic [1:0] SRCB_SHL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALU operation, purely combinational; valid_o is low for unsupported funct codes.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ct_o,
    output logic       valid_o
);

    always_comb begin
        alu_ct_o = ALU_AND;
        valid_o  = 1'b1;
        case (funct_i)
            FN_AND:  alu_ct_o = ALU_AND;
            FN_OR:   alu_ct_o = ALU_OR;
            FN_ADD:  alu_ct_o = ALU_ADD;
            FN_SUB:  alu_ct_o = ALU_SUB;
            default: valid_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM (Moore outputs, pc_en follows zero in BRANCH) with retired-instruction counter.
// MC_CONTROL_JUMP_EN enables the j instruction; without it opcode 000010 decodes as illegal.
module mc_control
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic [3:0]       alu_ct,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       fn_alu_ct;
    logic             fn_valid;

    alu_decoder u_alu_decoder (
        .funct_i  (funct),
        .alu_ct_o (fn_alu_ct),
        .valid_o  (fn_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = S_RST;
        cnt_d      = cnt_q;
        alu_ct     = ALU_AND;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        pc_source  = PCSRC_ALU;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_ct    = ALU_ADD;
                pc_source = PCSRC_ALU;
                pc_en     = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // ALU speculatively computes the branch target while the opcode is decoded
                alu_src_b = SRCB_SHL2;
                alu_ct    = ALU_ADD;
                state_d   = S_FETCH;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (fn_valid) state_d = S_EXEC;
                        else          illegal_op = 1'b1;
                    end
                    OP_BEQ: state_d = S_BRANCH;
`ifdef MC_CONTROL_JUMP_EN
                    OP_J:   state_d = S_JUMP;
`endif
                    default: illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_SEXT;
                alu_ct    = ALU_ADD;
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
                cnt_d      = cnt_q + CNT_ONE;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                state_d   = S_FETCH;
                cnt_d     = cnt_q + CNT_ONE;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_ct    = fn_alu_ct;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
                cnt_d     = cnt_q + CNT_ONE;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_ct    = ALU_SUB;
                pc_source = PCSRC_ALUOUT;
                pc_en     = zero;
                state_d   = S_FETCH;
                cnt_d     = cnt_q + CNT_ONE;
            end
`ifdef MC_CONTROL_JUMP_EN
            S_JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_en     = 1'b1;
                state_d   = S_FETCH;
                cnt_d     = cnt_q + CNT_ONE;
            end
`endif
            default: state_d = S_RST;
        endcase
    end

    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed-vector bench for mc_control: state sequence, per-state outputs and instruction count.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode, funct;
    logic        zero;
    logic [3:0]  alu_ct;
    logic        alu_src_a;
    logic [1:0]  alu_src_b, pc_source;
    logic        pc_en, iord, mem_read, mem_write, ir_write;
    logic        reg_write, reg_dst, mem_to_reg, illegal_op;
    logic [3:0]  state;
    logic [31:0] instr_count;
    logic [17:0] outs;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    mc_control #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .alu_ct      (alu_ct),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_source   (pc_source),
        .pc_en       (pc_en),
        .iord        (iord),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .illegal_op  (illegal_op),
        .state       (state),
        .instr_count (instr_count)
    );

    // {alu_ct, src_a, src_b, pc_source, pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal_op}
    assign outs = {alu_ct, alu_src_a, alu_src_b, pc_source, pc_en, iord, mem_read,
                   mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal_op};

    localparam logic [17:0] O_ZERO   = 18'b0000_0_00_00_0_0_0_0_0_0_0_0_0;
    localparam logic [17:0] O_FETCH  = 18'b0010_0_01_00_1_0_1_0_1_0_0_0_0;
    localparam logic [17:0] O_DECODE = 18'b0010_0_11_00_0_0_0_0_0_0_0_0_0;
    localparam logic [17:0] O_DEC_IL = 18'b0010_0_11_00_0_0_0_0_0_0_0_0_1;
    localparam logic [17:0] O_MEMADR = 18'b0010_1_10_00_0_0_0_0_0_0_0_0_0;
    localparam logic [17:0] O_MEMRD  = 18'b0000_0_00_00_0_1_1_0_0_0_0_0_0;
    localparam logic [17:0] O_MEMWB  = 18'b0000_0_00_00_0_0_0_0_0_1_0_1_0;
    localparam logic [17:0] O_MEMWR  = 18'b0000_0_00_00_0_1_0_1_0_0_0_0_0;
    localparam logic [17:0] O_EX_SUB = 18'b0110_1_00_00_0_0_0_0_0_0_0_0_0;
    localparam logic [17:0] O_EX_ADD = 18'b0010_1_00_00_0_0_0_0_0_0_0_0_0;
    localparam logic [17:0] O_ALUWB  = 18'b0000_0_00_00_0_0_0_0_0_1_1_0_0;
    localparam logic [17:0] O_BR_Z1  = 18'b0110_1_00_01_1_0_0_0_0_0_0_0_0;
    localparam logic [17:0] O_BR_Z0  = 18'b0110_1_00_01_0_0_0_0_0_0_0_0_0;
    localparam logic [17:0] O_JUMP   = 18'b0000_0_00_10_1_0_0_0_0_0_0_0_0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step_chk(input string tag, input logic [3:0] es, input logic [17:0] eo);
        @(posedge clk);
        #1;
        chk({tag, "_state"}, {28'd0, state}, {28'd0, es});
        chk({tag, "_outs"}, {14'd0, outs}, {14'd0, eo});
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 6'b000000;
        funct  = 6'b000000;
        zero   = 1'b0;
        #3;
        chk("rst_state", {28'd0, state}, 32'd0);
        chk("rst_outs", {14'd0, outs}, {14'd0, O_ZERO});
        chk("rst_cnt", instr_count, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_state", {28'd0, state}, 32'd0);

        // lw: 1,2,3,4,5,1
        @(negedge clk);
        rst_n  = 1'b1;
        opcode = 6'b100011;
        step_chk("lw_fetch", 4'd1, O_FETCH);
        step_chk("lw_decode", 4'd2, O_DECODE);
        step_chk("lw_memadr", 4'd3, O_MEMADR);
        step_chk("lw_memrd", 4'd4, O_MEMRD);
        step_chk("lw_memwb", 4'd5, O_MEMWB);
        step_chk("lw_end", 4'd1, O_FETCH);
        chk("lw_cnt", instr_count, 32'd1);

        // sw: 2,3,6,1
        opcode = 6'b101011;
        step_chk("sw_decode", 4'd2, O_DECODE);
        step_chk("sw_memadr", 4'd3, O_MEMADR);
        step_chk("sw_memwr", 4'd6, O_MEMWR);
        step_chk("sw_end", 4'd1, O_FETCH);
        chk("sw_cnt", instr_count, 32'd2);

        // R-type sub, then add
        opcode = 6'b000000;
        funct  = 6'b100010;
        step_chk("sub_decode", 4'd2, O_DECODE);
        step_chk("sub_exec", 4'd7, O_EX_SUB);
        step_chk("sub_aluwb", 4'd8, O_ALUWB);
        step_chk("sub_end", 4'd1, O_FETCH);
        chk("sub_cnt", instr_count, 32'd3);
        funct = 6'b100000;
        step_chk("add_decode", 4'd2, O_DECODE);
        step_chk("add_exec", 4'd7, O_EX_ADD);
        step_chk("add_aluwb", 4'd8, O_ALUWB);
        step_chk("add_end", 4'd1, O_FETCH);
        chk("add_cnt", instr_count, 32'd4);

        // beq taken then not taken
        opcode = 6'b000100;
        zero   = 1'b1;
        step_chk("beq1_decode", 4'd2, O_DECODE);
        step_chk("beq1_branch", 4'd9, O_BR_Z1);
        step_chk("beq1_end", 4'd1, O_FETCH);
        chk("beq1_cnt", instr_count, 32'd5);
        zero = 1'b0;
        step_chk("beq0_decode", 4'd2, O_DECODE);
        step_chk("beq0_branch", 4'd9, O_BR_Z0);
        step_chk("beq0_end", 4'd1, O_FETCH);
        chk("beq0_cnt", instr_count, 32'd6);

        // illegal opcode and illegal funct: one-cycle pulse, no count
        opcode = 6'b111111;
        step_chk("ilop_decode", 4'd2, O_DEC_IL);
        step_chk("ilop_end", 4'd1, O_FETCH);
        chk("ilop_cnt", instr_count, 32'd6);
        opcode = 6'b000000;
        funct  = 6'b101010;
        step_chk("ilfn_decode", 4'd2, O_DEC_IL);
        step_chk("ilfn_end", 4'd1, O_FETCH);
        chk("ilfn_cnt", instr_count, 32'd6);

        // j: JUMP when enabled, illegal otherwise
        opcode = 6'b000010;
`ifdef MC_CONTROL_JUMP_EN
        step_chk("j_decode", 4'd2, O_DECODE);
        step_chk("j_jump", 4'd10, O_JUMP);
        step_chk("j_end", 4'd1, O_FETCH);
        chk("j_cnt", instr_count, 32'd7);
`else
        step_chk("j_decode", 4'd2, O_DEC_IL);
        step_chk("j_end", 4'd1, O_FETCH);
        chk("j_cnt", instr_count, 32'd6);
`endif

        // asynchronous reset in MEMRD
        opcode = 6'b100011;
        step_chk("rlw_decode", 4'd2, O_DECODE);
        step_chk("rlw_memadr", 4'd3, O_MEMADR);
        step_chk("rlw_memrd", 4'd4, O_MEMRD);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_state", {28'd0, state}, 32'd0);
        chk("arst_outs", {14'd0, outs}, {14'd0, O_ZERO});
        chk("arst_cnt", instr_count, 32'd0);
        #1;
        rst_n = 1'b1;
        step_chk("arst_fetch", 4'd1, O_FETCH);
        chk("arst_fetch_cnt", instr_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
